// File: rtl/gf_sqsc_mul_4_masked_pipe.sv
`default_nettype none
// ============================================================================
// Module      : gf_sqsc_mul_4_masked_pipe
// Description : Two-stage, first-order masked computation of
//               sqsc(x_h ^ x_l) ^ mul4(x_h, x_l) over GF(2^4) in the
//               normal basis [alpha^8, alpha^2] / GF(2^2) [W^2, W] tower.
//               Stage 1 forms five share-cross terms and stage 2 folds them
//               in a fixed order. The fold starts with the fresh mask, so no
//               unmasked value ever appears. Valid/ready flow control.
// Revision    : 1.0 - initial release
// ============================================================================
module gf_sqsc_mul_4_masked_pipe (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] in_data,
    input  logic [7:0] in_mask,
    input  logic [3:0] in_rand,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [3:0] out_data,
    output logic [3:0] out_mask,
    output logic [7:0] out_a,
    output logic [7:0] out_m
);

    // GF(2^2) multiply, normal basis [W^2, W]
    function automatic logic [1:0] gf2_mul(input logic [1:0] a, input logic [1:0] b);
        logic t;
        t = (a[1] ^ a[0]) & (b[1] ^ b[0]);
        return {(a[1] & b[1]) ^ t, (a[0] & b[0]) ^ t};
    endfunction

    // GF(2^2) scale by N = W^2
    function automatic logic [1:0] gf2_scl_n(input logic [1:0] a);
        return {a[0], a[1] ^ a[0]};
    endfunction

    // GF(2^2) scale by N^2 = W
    function automatic logic [1:0] gf2_scl_n2(input logic [1:0] a);
        return {a[1] ^ a[0], a[1]};
    endfunction

    // GF(2^2) square: a bit swap in normal basis
    function automatic logic [1:0] gf2_sq(input logic [1:0] a);
        return {a[0], a[1]};
    endfunction

    // GF(2^4) multiply over the GF(2^2) tower
    function automatic logic [3:0] gf4_mul(input logic [3:0] a, input logic [3:0] b);
        logic [1:0] ph;
        logic [1:0] pl;
        logic [1:0] p;
        ph = gf2_mul(a[3:2], b[3:2]);
        pl = gf2_mul(a[1:0], b[1:0]);
        p  = gf2_scl_n(gf2_mul(a[3:2] ^ a[1:0], b[3:2] ^ b[1:0]));
        return {ph ^ p, pl ^ p};
    endfunction

    // GF(2^4) square-then-scale by nu
    function automatic logic [3:0] gf4_sqsc(input logic [3:0] a);
        return {gf2_sq(a[3:2] ^ a[1:0]), gf2_scl_n2(gf2_sq(a[1:0]))};
    endfunction

    logic [3:0] ah;
    logic [3:0] al;
    logic [3:0] mh;
    logic [3:0] ml;
    logic       s1_valid;
    logic       s2_valid;
    logic       accept;
    logic       s2_load;
    logic [3:0] u0;
    logic [3:0] u1;
    logic [3:0] u2;
    logic [3:0] u3;
    logic [3:0] u4;
    logic [3:0] s1_rand;
    logic [7:0] s1_a;
    logic [7:0] s1_m;

    assign ah = in_data[7:4];
    assign al = in_data[3:0];
    assign mh = in_mask[7:4];
    assign ml = in_mask[3:0];

    // Ready is a function of occupancy and downstream only, never of in_valid
    assign in_ready  = !s1_valid || !s2_valid || out_ready;
    assign accept    = in_valid && in_ready;
    assign s2_load   = s1_valid && (!s2_valid || out_ready);
    assign out_valid = s2_valid;

    // Stage 1 occupancy: fills on accept, empties when stage 2 takes it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
        end else begin
            s1_valid <= accept || (s1_valid && !s2_load);
        end
    end

    // Stage 1 terms; fresh mask R is folded into u0 so every later sum is masked
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            u0      <= 4'h0;
            u1      <= 4'h0;
            u2      <= 4'h0;
            u3      <= 4'h0;
            u4      <= 4'h0;
            s1_rand <= 4'h0;
            s1_a    <= 8'h00;
            s1_m    <= 8'h00;
        end else if (accept) begin
            u0      <= in_rand ^ gf4_mul(ah, al);
            u1      <= gf4_mul(ah, ml);
            u2      <= gf4_mul(mh, al);
            u3      <= gf4_mul(mh, ml) ^ gf4_sqsc(mh ^ ml);
            u4      <= gf4_sqsc(ah ^ al);
            s1_rand <= in_rand;
            s1_a    <= in_data;
            s1_m    <= in_mask;
        end
    end

    // Stage 2 occupancy: loads from stage 1, empties on downstream handshake
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid <= 1'b0;
        end else begin
            s2_valid <= s2_load || (s2_valid && !out_ready);
        end
    end

    // Stage 2 fold in fixed order starting from the R-carrying term
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data <= 4'h0;
            out_mask <= 4'h0;
            out_a    <= 8'h00;
            out_m    <= 8'h00;
        end else if (s2_load) begin
            out_data <= (((u0 ^ u1) ^ u2) ^ u3) ^ u4;
            out_mask <= s1_rand;
            out_a    <= s1_a;
            out_m    <= s1_m;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_gf_sqsc_mul_4_masked_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_gf_sqsc_mul_4_masked_pipe
// Description : Scoreboard bench for the masked GF(2^4) sqsc/mul pipe with a
//               polynomial-tower reference model of GF(2^4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_gf_sqsc_mul_4_masked_pipe;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] in_data = 8'h00;
    logic [7:0] in_mask = 8'h00;
    logic [3:0] in_rand = 4'h0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [3:0] out_data;
    logic [3:0] out_mask;
    logic [7:0] out_a;
    logic [7:0] out_m;

    gf_sqsc_mul_4_masked_pipe dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_mask   (in_mask),
        .in_rand   (in_rand),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_mask  (out_mask),
        .out_a     (out_a),
        .out_m     (out_m)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] c;
        logic [3:0] r;
        logic [7:0] a;
        logic [7:0] m;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    bit   rand_ready = 1'b0;
    bit   hist_en = 1'b0;
    int   hist[16];

    // ---------------- reference model ----------------
    // GF(4) codes: 0 -> 0, 1 -> W, 2 -> W^2, 3 -> 1; log/antilog arithmetic
    function automatic int f4_log(input int a);
        case (a)
            1: return 1;
            2: return 2;
            default: return 0;
        endcase
    endfunction

    function automatic int f4_exp(input int e);
        case (e % 3)
            0: return 3;
            1: return 1;
            default: return 2;
        endcase
    endfunction

    function automatic int f4_mul(input int a, input int b);
        if (a == 0 || b == 0) return 0;
        return f4_exp(f4_log(a) + f4_log(b));
    endfunction

    // GF(16) = GF(4)[Y]/(Y^2+Y+N), N=W^2. Normal coords (h,l) = h*Y^4 + l*Y,
    // with Y^4 = 1 + Y, i.e. polynomial form h + (h^l)Y.
    function automatic logic [3:0] f16_mul(input logic [3:0] x, input logic [3:0] y);
        int a0, a1, b0, b1, c0, c1;
        a0 = int'(x[3:2]); a1 = int'(x[3:2] ^ x[1:0]);
        b0 = int'(y[3:2]); b1 = int'(y[3:2] ^ y[1:0]);
        c0 = f4_mul(a0, b0) ^ f4_mul(f4_mul(a1, b1), 2);
        c1 = f4_mul(a0, b1) ^ f4_mul(a1, b0) ^ f4_mul(a1, b1);
        return {2'(c0), 2'(c0 ^ c1)};
    endfunction

    function automatic logic [3:0] model_c(input logic [7:0] a, input logic [7:0] m);
        logic [7:0] x;
        logic [3:0] s;
        x = a ^ m;
        s = x[7:4] ^ x[3:0];
        return f16_mul(4'h1, f16_mul(s, s)) ^ f16_mul(x[7:4], x[3:0]);
    endfunction

    // ---------------- helpers ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        if (rand_ready) out_ready = 1'($urandom_range(0, 1));
    endtask

    // Drive one transaction until accepted; the expectation is queued on acceptance
    task automatic send(input logic [7:0] a, input logic [7:0] m, input logic [3:0] r);
        int   n;
        exp_t e;
        n = 0;
        in_valid = 1'b1; in_data = a; in_mask = m; in_rand = r;
        forever begin
            @(negedge clk);
            if (in_ready) begin
                e.c = model_c(a, m); e.r = r; e.a = a; e.m = m;
                sb.push_back(e);
                break;
            end
            n++;
            if (n > 200) begin
                checks++; errors++;
                $display("FAIL accept_timeout: in_ready stuck 0 expected 1");
                break;
            end
            step();
        end
        step();
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((sb.size() != 0 || out_valid) && n < 500) begin
            step();
            n++;
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d results outstanding expected 0", sb.size());
        end
    endtask

    // ---------------- monitor ----------------
    initial begin : monitor
        exp_t       e;
        bit         stall_prev;
        logic [3:0] hd, hm;
        logic [7:0] ha, hmm;
        stall_prev = 1'b0;
        hd = '0; hm = '0; ha = '0; hmm = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                stall_prev = 1'b0;
            end else begin
                if (stall_prev) begin
                    chk("stall_valid", 32'(out_valid), 32'd1);
                    chk("stall_data", 32'(out_data), 32'(hd));
                    chk("stall_mask", 32'(out_mask), 32'(hm));
                    chk("stall_a", 32'(out_a), 32'(ha));
                    chk("stall_m", 32'(out_m), 32'(hmm));
                end
                if (out_valid && out_ready) begin
                    if (sb.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL unexpected_output: got data %0h expected none", out_data);
                    end else begin
                        e = sb.pop_front();
                        chk("unmasked_c", 32'(out_data ^ out_mask), 32'(e.c));
                        chk("out_mask", 32'(out_mask), 32'(e.r));
                        chk("out_a", 32'(out_a), 32'(e.a));
                        chk("out_m", 32'(out_m), 32'(e.m));
                        if (hist_en) hist[out_data]++;
                    end
                end
                stall_prev = out_valid && !out_ready;
                hd = out_data; hm = out_mask; ha = out_a; hmm = out_m;
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin : driver
        logic [7:0] m;
        real        chi;
        for (int i = 0; i < 16; i++) hist[i] = 0;

        // Reset state
        #2;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_data", {out_a, out_m, out_data, out_mask}, 32'd0);
        step(); step();
        rst_n = 1'b1;
        out_ready = 1'b1;

        // Basic transaction with latency check
        send(8'h00, 8'h00, 4'h5);
        @(negedge clk);
        chk("lat_early", 32'(out_valid), 32'd0);
        @(negedge clk);
        chk("lat_valid", 32'(out_valid), 32'd1);
        chk("basic_data", 32'(out_data), 32'h5);
        chk("basic_mask", 32'(out_mask), 32'h5);
        drain();

        // Masked unity input
        send(8'hA5, 8'h5A, 4'h3);
        @(negedge clk);
        @(negedge clk);
        chk("unity_data", 32'(out_data), 32'hC);
        drain();

        // Random sweep over every x with random masks and backpressure
        rand_ready = 1'b1;
        for (int x = 0; x < 256; x++) begin
            m = 8'($urandom);
            send(8'(x) ^ m, m, 4'($urandom));
            if ($urandom_range(0, 3) == 0) step();
        end
        drain();
        rand_ready = 1'b0;

        // Full-stall boundary
        out_ready = 1'b0;
        send(8'h12, 8'h34, 4'h6);
        send(8'h9C, 8'h47, 4'hB);
        in_valid = 1'b1; in_data = 8'hE1; in_mask = 8'h2D; in_rand = 4'h9;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("full_in_ready", 32'(in_ready), 32'd0);
            step();
        end
        out_ready = 1'b1;
        send(8'hE1, 8'h2D, 4'h9);
        @(negedge clk);
        chk("drain_accept_valid", 32'(out_valid), 32'd1);
        drain();

        // Reset mid-flight
        out_ready = 1'b0;
        send(8'h55, 8'h0F, 4'h1);
        send(8'h77, 8'hF0, 4'h2);
        rst_n = 1'b0;
        #1;
        chk("midrst_valid", 32'(out_valid), 32'd0);
        chk("midrst_ready", 32'(in_ready), 32'd1);
        chk("midrst_data", {out_a, out_m, out_data, out_mask}, 32'd0);
        sb.delete();
        step(); step();
        rst_n = 1'b1;
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("no_stale", 32'(out_valid), 32'd0);
            step();
        end
        send(8'h3C, 8'hC3, 4'hA);
        @(negedge clk);
        @(negedge clk);
        chk("post_rst_lat", 32'(out_valid), 32'd1);
        drain();

        // Output distribution for a fixed x under random M and R
        hist_en = 1'b1;
        for (int k = 0; k < 1000; k++) begin
            m = 8'($urandom);
            send(8'h6B ^ m, m, 4'($urandom));
        end
        drain();
        hist_en = 1'b0;
        chi = 0.0;
        for (int i = 0; i < 16; i++)
            chi += ((real'(hist[i]) - 62.5) * (real'(hist[i]) - 62.5)) / 62.5;
        checks++;
        if (chi > 60.0) begin
            errors++;
            $display("FAIL chi_square: got %0f expected below 60", chi);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
